// File: rtl/div_if.sv
// div_if: start/busy handshake and result bus of the sequential divider
interface div_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             start_in;
  logic             busy_out;
  logic             valid_out;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             dbz_out;
  modport master (output a_in, b_in, start_in, input busy_out, valid_out, q_out, r_out, dbz_out);
  modport slave  (input a_in, b_in, start_in, output busy_out, valid_out, q_out, r_out, dbz_out);
endinterface

// File: rtl/div.sv
// div: sequential unsigned restoring divider, one quotient bit per clock
module div #(parameter int WIDTH = 8) (
  input logic  clk_in,
  input logic  rst_n_in,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, WORK, WAIT} state_t;
  state_t           state_q;
  logic [CW-1:0]    ctr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_flag_q;
  logic             dbz_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH:0]   s_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  logic             last_d;
  // one restoring step; the kept remainder is always below 2**WIDTH so WIDTH bits hold it
  always_comb begin
    s_d    = {rem_q, quot_q[WIDTH-1]};
    diff_d = s_d - {1'b0, div_q};
    rem_d  = diff_d[WIDTH] ? s_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
    quot_d = {quot_q[WIDTH-2:0], ~diff_d[WIDTH]};
    last_d = ctr_q == CW'(WIDTH - 1);
  end
  // control FSM, datapath iteration and registered results
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      div_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_flag_q <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_in) begin
          quot_q     <= bus.a_in;
          div_q      <= bus.b_in;
          rem_q      <= '0;
          ctr_q      <= '0;
          dbz_flag_q <= bus.b_in == '0;
          busy_q     <= 1'b1;
          state_q    <= WORK;
        end
        WORK: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          ctr_q  <= ctr_q + CW'(1);
          if (last_d) begin
            q_q     <= quot_d;
            r_q     <= rem_d;
            dbz_q   <= dbz_flag_q;
            valid_q <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy_out  = busy_q;
  assign bus.valid_out = valid_q;
  assign bus.q_out     = q_q;
  assign bus.r_out     = r_q;
  assign bus.dbz_out   = dbz_q;
endmodule

// File: tb/tb_div.sv
// tb_div: directed and model-checked vectors for the sequential divider
module tb_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] prev_q = '0;
  logic [7:0] prev_r = '0;
  div_if #(.WIDTH(8)) bus ();
  div #(.WIDTH(8)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy_out && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy_out) chk("idle_timeout", 1, 0);
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                    input logic [7:0] er, input logic edbz, input string tag);
    int bc = 0;
    int vc = 0;
    int vat = -1;
    bus.a_in = a;
    bus.b_in = b;
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    for (int n = 0; n < 20 && bus.busy_out; n++) begin
      bc++;
      if (n == 2) begin
        bus.a_in = ~a;
        bus.b_in = b ^ 8'h55;
        bus.start_in = 1'b1;
      end
      if (n == 4) chk({tag, "_hold_q"}, bus.q_out, prev_q);
      if (bus.valid_out) begin
        vc++;
        vat = n;
        chk({tag, "_q"}, bus.q_out, eq);
        chk({tag, "_r"}, bus.r_out, er);
        chk({tag, "_dbz"}, bus.dbz_out, edbz);
      end
      @(posedge clk); #1;
    end
    bus.start_in = 1'b0;
    chk({tag, "_busy_cycles"}, bc, 9);
    chk({tag, "_valid_count"}, vc, 1);
    chk({tag, "_valid_at"}, vat, 8);
    prev_q = eq;
    prev_r = er;
  endtask
  initial begin
    int last;
    int pulses;
    logic [7:0] ra;
    logic [7:0] rb;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.start_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_q", bus.q_out, 0);
    chk("rst_r", bus.r_out, 0);
    chk("rst_dbz", bus.dbz_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "t1");
    op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "t2a");
    op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, "t2b");
    op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "t2c");
    op(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, "t3a");
    op(8'd6, 8'd3, 8'd2, 8'd0, 1'b0, "t3b");
    op(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, "zero_zero");
    op(8'd128, 8'd128, 8'd1, 8'd0, 1'b0, "eq128");
    last = -1;
    pulses = 0;
    bus.a_in = 8'd200;
    bus.b_in = 8'd9;
    bus.start_in = 1'b1;
    for (int c = 0; c < 35; c++) begin
      @(posedge clk); #1;
      if (bus.valid_out) begin
        pulses++;
        chk("t4_q", bus.q_out, 22);
        chk("t4_r", bus.r_out, 2);
        if (last >= 0) chk("t4_gap", c - last, 10);
        last = c;
      end
      bus.a_in = bus.busy_out ? 8'd17 : 8'd200;
      bus.b_in = bus.busy_out ? 8'd250 : 8'd9;
    end
    bus.start_in = 1'b0;
    chk("t4_pulses", pulses, 3);
    wait_idle();
    prev_q = 8'd22;
    prev_r = 8'd2;
    bus.a_in = 8'd100;
    bus.b_in = 8'd7;
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", bus.busy_out, 0);
    chk("t5_q", bus.q_out, 0);
    chk("t5_r", bus.r_out, 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.valid_out) pulses++;
    end
    chk("t5_no_valid", pulses, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev_q = '0;
    prev_r = '0;
    op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "t5_restart");
    for (int i = 0; i < 120; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      op(ra, rb, rb == 0 ? 8'd255 : ra / rb, rb == 0 ? ra : ra % rb, rb == 0, "sweep");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
